// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, ALU operation codes, writeback-source
// codes, the decoded control bundle and the ALU-op selection helper.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Control bundle produced by the decoder and carried through ID/EX.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic       alu_src_a;
    logic [1:0] result_src;
    logic [3:0] alu_control;
  } ctrl_t;

  // Immediate format selected by the decoder.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_sel_e;

  // ALU op for R-type and I-ALU instructions. funct7[5] selects SUB only for
  // R-type add, and selects SRA for shift-right in both formats.
  function automatic logic [3:0] alu_op(input logic [2:0] funct3,
                                        input logic       funct7b5,
                                        input logic       is_r);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: NREG x XLEN, two combinational read ports,
// one synchronous write port. x0 reads as zero and ignores writes; a read of
// the register being written this cycle returns the write data.
module regfile
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [NREG];
  logic            wr_ok;

  assign wr_ok = we && (wa != 5'd0) && (32'(wa) < NREG);

  // Write port; reset clears every entry and drops any in-flight write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  // Read ports with x0 forced to zero and write-through bypass.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0) begin
      if (wr_ok && wa == ra1)      rd1 = wd;
      else if (32'(ra1) < NREG)    rd1 = mem[ra1];
    end
    if (ra2 != 5'd0) begin
      if (wr_ok && wa == ra2)      rd2 = wd;
      else if (32'(ra2) < NREG)    rd2 = mem[ra2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decoder, immediate generator, register
// file and the ID/EX pipeline register feeding the execute stage.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] PCD,
  input  logic            stallD,
  input  logic            flushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            JalrE,
  output logic            ALUSrcE,
  output logic            ALUSrcAE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [2:0]      funct3E
);

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
  } idex_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  ctrl_t           ctrl_d;
  imm_sel_e        imm_sel;
  logic [31:0]     imm32;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  idex_t           d;
  idex_t           q;

  assign opcode   = instrD[6:0];
  assign funct3   = instrD[14:12];
  assign funct7b5 = instrD[30];

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (instrD[19:15]),
    .ra2 (instrD[24:20]),
    .rd1 (rd1_d),
    .rd2 (rd2_d),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW)
  );

  // Main decoder: opcode to control bundle and immediate format; unknown
  // opcodes leave every control at 0 so they behave as a bubble.
  always_comb begin
    ctrl_d  = '0;
    imm_sel = IMM_NONE;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_control = alu_op(funct3, funct7b5, 1'b1);
      end
      OP_I: begin
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = alu_op(funct3, funct7b5, 1'b0);
        imm_sel            = IMM_I;
      end
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_MEM;
        imm_sel           = IMM_I;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_sel          = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_d.branch      = 1'b1;
        ctrl_d.alu_control = ALU_SUB;
        imm_sel            = IMM_B;
      end
      OP_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jump       = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_PC4;
        imm_sel           = IMM_J;
      end
      OP_JALR: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jalr       = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_PC4;
        imm_sel           = IMM_I;
      end
      OP_LUI: begin
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = ALU_PASSB;
        imm_sel            = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_src_a = 1'b1;
        imm_sel          = IMM_U;
      end
      default: ;
    endcase
  end

  // Immediate generator; every format sign-extends from instruction bit 31.
  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I:   imm32 = {{20{instrD[31]}}, instrD[31:20]};
      IMM_S:   imm32 = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      IMM_B:   imm32 = {{19{instrD[31]}}, instrD[31], instrD[7],
                        instrD[30:25], instrD[11:8], 1'b0};
      IMM_J:   imm32 = {{11{instrD[31]}}, instrD[31], instrD[19:12],
                        instrD[20], instrD[30:21], 1'b0};
      IMM_U:   imm32 = {instrD[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  // Assemble the next ID/EX contents from the decoded instruction.
  always_comb begin
    d        = '0;
    d.ctrl   = ctrl_d;
    d.rd1    = rd1_d;
    d.rd2    = rd2_d;
    d.imm    = XLEN'($signed(imm32));
    d.pc     = PCD;
    d.rs1    = instrD[19:15];
    d.rs2    = instrD[24:20];
    d.rd     = instrD[11:7];
    d.funct3 = funct3;
  end

  // ID/EX register. Priority: flushE loads an all-zero bubble, otherwise
  // stallD holds the current contents, otherwise the decoded instruction is
  // captured. The register file write port is unaffected by either.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (flushE) begin
      q <= '0;
    end else if (!stallD) begin
      q <= d;
    end
  end

  assign RegWriteE   = q.ctrl.reg_write;
  assign MemWriteE   = q.ctrl.mem_write;
  assign BranchE     = q.ctrl.branch;
  assign JumpE       = q.ctrl.jump;
  assign JalrE       = q.ctrl.jalr;
  assign ALUSrcE     = q.ctrl.alu_src;
  assign ALUSrcAE    = q.ctrl.alu_src_a;
  assign ResultSrcE  = q.ctrl.result_src;
  assign ALUControlE = q.ctrl.alu_control;
  assign RD1E        = q.rd1;
  assign RD2E        = q.rd2;
  assign ImmExtE     = q.imm;
  assign PCE         = q.pc;
  assign Rs1E        = q.rs1;
  assign Rs2E        = q.rs2;
  assign RdE         = q.rd;
  assign funct3E     = q.funct3;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases followed by random
// instruction/writeback/stall/flush traffic checked against a behavioural
// model of the decode rules and an array model of the register file.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]     instrD;
  logic [XLEN-1:0] PCD;
  logic            stallD, flushE, RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, ALUSrcAE;
  logic [1:0]      ResultSrcE;
  logic [3:0]      ALUControlE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic [2:0]      funct3E;

  decode_stage #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .PCD(PCD),
    .stallD(stallD), .flushE(flushE),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .JumpE(JumpE), .JalrE(JalrE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .funct3E(funct3E)
  );

  // ---------------- model state / scoreboard ----------------
  typedef struct packed {
    logic        regwrite, memwrite, branch, jump, jalr, alusrc, alusrca;
    logic [1:0]  resultsrc;
    logic [3:0]  aluctl;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        imm_chk;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  exp_t        zero_e;
  logic [31:0] regs [NREG];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    check("RegWriteE",   64'(RegWriteE),   64'(e.regwrite));
    check("MemWriteE",   64'(MemWriteE),   64'(e.memwrite));
    check("BranchE",     64'(BranchE),     64'(e.branch));
    check("JumpE",       64'(JumpE),       64'(e.jump));
    check("JalrE",       64'(JalrE),       64'(e.jalr));
    check("ALUSrcE",     64'(ALUSrcE),     64'(e.alusrc));
    check("ALUSrcAE",    64'(ALUSrcAE),    64'(e.alusrca));
    check("ResultSrcE",  64'(ResultSrcE),  64'(e.resultsrc));
    check("ALUControlE", 64'(ALUControlE), 64'(e.aluctl));
    check("RD1E",        64'(RD1E),        64'(e.rd1));
    check("RD2E",        64'(RD2E),        64'(e.rd2));
    check("PCE",         64'(PCE),         64'(e.pc));
    check("Rs1E",        64'(Rs1E),        64'(e.rs1));
    check("Rs2E",        64'(Rs2E),        64'(e.rs2));
    check("RdE",         64'(RdE),         64'(e.rd));
    check("funct3E",     64'(funct3E),     64'(e.f3));
    if (e.imm_chk) check("ImmExtE", 64'(ImmExtE), 64'(e.imm));
  endtask

  // Register-file read as seen by the instruction in decode this cycle.
  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && RdW == a) return ResultW;
    return regs[a];
  endfunction

  // Behavioural decode reference, written from the instruction-set rules.
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] v1, input logic [31:0] v2);
    exp_t       e;
    int         s;
    logic [3:0] f3tab [8];
    logic [2:0] f3;
    f3tab = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};
    s     = $signed(ins);
    f3    = ins[14:12];
    e     = '0;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
    e.pc  = pc; e.rd1 = v1; e.rd2 = v2;
    e.imm_chk = 1'b1;
    case (ins[6:0])
      7'b0110011: begin
        e.regwrite = 1; e.aluctl = f3tab[f3]; e.imm_chk = 1'b0;
        if (ins[30] && f3 == 3'd0) e.aluctl = 4'h1;
        if (ins[30] && f3 == 3'd5) e.aluctl = 4'h7;
      end
      7'b0010011: begin
        e.regwrite = 1; e.alusrc = 1; e.aluctl = f3tab[f3]; e.imm = s >>> 20;
        if (ins[30] && f3 == 3'd5) e.aluctl = 4'h7;
      end
      7'b0000011: begin e.regwrite = 1; e.alusrc = 1; e.resultsrc = 2'd1; e.imm = s >>> 20; end
      7'b0100011: begin
        e.memwrite = 1; e.alusrc = 1;
        e.imm = ((s >>> 25) << 5) + int'(ins[11:7]);
      end
      7'b1100011: begin
        e.branch = 1; e.aluctl = 4'h1;
        e.imm = ((s >>> 31) << 12) + (int'(ins[7]) << 11) + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
      end
      7'b1101111: begin
        e.regwrite = 1; e.jump = 1; e.alusrc = 1; e.resultsrc = 2'd2;
        e.imm = ((s >>> 31) << 20) + (int'(ins[19:12]) << 12) + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1);
      end
      7'b1100111: begin
        e.regwrite = 1; e.jalr = 1; e.alusrc = 1; e.resultsrc = 2'd2; e.imm = s >>> 20;
      end
      7'b0110111: begin e.regwrite = 1; e.alusrc = 1; e.aluctl = 4'hA; e.imm = ins & 32'hFFFFF000; end
      7'b0010111: begin e.regwrite = 1; e.alusrc = 1; e.alusrca = 1; e.imm = ins & 32'hFFFFF000; end
      default: e.imm_chk = 1'b0;
    endcase
    return e;
  endfunction

  // ---------------- driver ----------------
  // Drive one decode cycle, predict the ID/EX contents after the edge,
  // advance the register-file model, then check #1 after the edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                      input logic stall, input logic flush,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t nxt;
    instrD = ins; PCD = pc; stallD = stall; flushE = flush;
    RegWriteW = we; RdW = wa; ResultW = wd;
    if (flush)      nxt = zero_e;
    else if (stall) nxt = cur;
    else            nxt = model_decode(ins, pc, rf_read(ins[19:15]), rf_read(ins[24:20]));
    exp_q.push_back(nxt);
    cur = nxt;
    if (we && wa != 5'd0) regs[wa] = wd;
    @(posedge clk);
    #1;
    compare_outputs(exp_q.pop_front());
  endtask

  task automatic idle_wb(input logic [31:0] ins, input logic [4:0] wa, input logic [31:0] wd);
    step(ins, 32'h100, 1'b0, 1'b0, 1'b1, wa, wd);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] opc_tab [10];

  initial begin
    logic [31:0] ins;
    zero_e = '0;
    zero_e.imm_chk = 1'b1;
    cur = zero_e;
    for (int i = 0; i < NREG; i++) regs[i] = 32'd0;
    opc_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};

    rst = 1'b0; instrD = 32'h00500093; PCD = 32'h40; stallD = 0; flushE = 0;
    RegWriteW = 0; RdW = 0; ResultW = 0;
    #1;
    compare_outputs(zero_e);
    repeat (2) @(posedge clk);
    #1;
    compare_outputs(zero_e);
    @(negedge clk);
    rst = 1'b1;

    // addi x1,x0,5
    step(32'h00500093, 32'h0000_0040, 0, 0, 0, 0, 0);
    check("addi_regwrite", 64'(RegWriteE), 64'd1);
    check("addi_alusrc",   64'(ALUSrcE),   64'd1);
    check("addi_imm",      64'(ImmExtE),   64'd5);
    check("addi_rd",       64'(RdE),       64'd1);
    check("addi_rs1",      64'(Rs1E),      64'd0);
    check("addi_alu",      64'(ALUControlE), 64'd0);

    // add x4,x3,x3 with same-cycle writeback of x3
    step(32'h00318233, 32'h44, 0, 0, 1, 5'd3, 32'hDEADBEEF);
    check("bypass_rd1", 64'(RD1E), 64'hDEADBEEF);
    check("bypass_rd2", 64'(RD2E), 64'hDEADBEEF);
    check("bypass_rd",  64'(RdE),  64'd4);

    // beq x0,x0,-4 and sw x2,8(x1)
    step(32'hFE000EE3, 32'h48, 0, 0, 0, 0, 0);
    check("beq_imm",      64'(ImmExtE),     64'hFFFFFFFC);
    check("beq_branch",   64'(BranchE),     64'd1);
    check("beq_alu",      64'(ALUControlE), 64'd1);
    check("beq_regwrite", 64'(RegWriteE),   64'd0);
    step(32'h0020A423, 32'h4C, 0, 0, 0, 0, 0);
    check("sw_imm",      64'(ImmExtE),   64'd8);
    check("sw_memwrite", 64'(MemWriteE), 64'd1);
    check("sw_regwrite", 64'(RegWriteE), 64'd0);

    // write x0 then add x0,x0,x0
    idle_wb(32'h0000007F, 5'd0, 32'h1234);
    step(32'h00000033, 32'h50, 0, 0, 0, 0, 0);
    check("x0_rd1", 64'(RD1E), 64'd0);
    check("x0_rd2", 64'(RD2E), 64'd0);

    // flush, stall, and both together
    step(32'h00500093, 32'h54, 0, 1, 0, 0, 0);
    check("flush_regwrite", 64'(RegWriteE), 64'd0);
    step(32'h00500093, 32'h58, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(32'h0020A423 + 32'(k << 7), 32'h60 + 32'(k * 4), 1, 0, 0, 0, 0);
      check("stall_imm", 64'(ImmExtE), 64'd5);
      check("stall_pc",  64'(PCE),     64'h58);
    end
    step(32'h00500093, 32'h6C, 1, 1, 0, 0, 0);
    check("stallflush_regwrite", 64'(RegWriteE), 64'd0);
    check("stallflush_alusrc",   64'(ALUSrcE),   64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ins = ($urandom & 32'hFFFFFF80) | 32'(opc_tab[$urandom_range(0, 9)]);
      if ($urandom_range(0, 9) == 0) ins = $urandom;
      step(ins, $urandom & 32'hFFFFFFFC,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end

    // mid-stream reset with a pending writeback
    idle_wb(32'h00500093, 5'd5, 32'h11111111);
    idle_wb(32'h00500093, 5'd6, 32'h22222222);
    #2;
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h33333333;
    rst = 1'b0;
    #1;
    compare_outputs(zero_e);
    for (int i = 0; i < NREG; i++) regs[i] = 32'd0;
    cur = zero_e;
    @(posedge clk);
    #1;
    compare_outputs(zero_e);
    RegWriteW = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // add x8,x5,x6 then add x8,x7,x7
    step(32'h00628433, 32'h80, 0, 0, 0, 0, 0);
    check("post_reset_x5", 64'(RD1E), 64'd0);
    check("post_reset_x6", 64'(RD2E), 64'd0);
    step(32'h00738433, 32'h84, 0, 0, 0, 0, 0);
    check("post_reset_x7", 64'(RD1E), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter NREG, default 32: number of architectural registers.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 instrD  input  32  instruction word held in the IF/ID register.
REQ-006 PCD  input  XLEN  PC of instrD.
REQ-007 stallD  input  1  hold the ID/EX register.
REQ-008 flushE  input  1  insert a bubble into the ID/EX register.
REQ-009 RegWriteW, RdW[4:0], ResultW[XLEN-1:0]  input  writeback port.
REQ-010 RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, ALUSrcAE  output  1 each  registered control.
REQ-011 ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4.
REQ-012 ALUControlE  output  4  ALU operation code.
REQ-013 RD1E, RD2E, ImmExtE, PCE  output  XLEN  registered operands, immediate and PC.
REQ-014 Rs1E, Rs2E, RdE  output  5 each; funct3E  output  3.

Function
REQ-015 Decode opcodes R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111), JALR (1100111), LUI (0110111), AUIPC (0010111).
REQ-016 Any other opcode decodes as a bubble: all write/branch/jump controls 0.
REQ-017 Immediates sign-extended from bit 31: I, S, B (bit0=0), J (bit0=0), U (low 12 bits 0).
REQ-018 ALUControl: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.
REQ-019 SUB only for R-type funct7[5]=1 with funct3 000; SRA for funct3 101 with funct7[5]=1 (R and I); LOAD/STORE/JAL/JALR/AUIPC use ADD; BRANCH uses SUB; LUI uses PASSB.
REQ-020 ALUSrcAE=1 (operand A = PC) only for AUIPC; ALUSrcE=1 for all non-R, non-BRANCH opcodes.
REQ-021 Register file: NREG x XLEN, two combinational read ports (rs1=instrD[19:15], rs2=instrD[24:20]), one synchronous write port.
REQ-022 Reading x0 returns 0; writes to x0 are ignored.
REQ-023 Same-cycle write and read of the same nonzero register returns ResultW (write-through bypass).
REQ-024 ID/EX register latency: one cycle from instrD to E outputs.
REQ-025 flushE=1: next edge loads all control outputs with 0; data fields don't-care but loaded with 0.
REQ-026 stallD=1, flushE=0: all E outputs hold.
REQ-027 flushE and stallD both 1: flush wins.
REQ-028 Register-file writes occur regardless of stallD/flushE.

Reset
REQ-029 rst low asynchronously clears every E output to 0 and every register-file entry to 0.
REQ-030 Reset asserted mid-operation discards any pending writeback in that cycle; first update after release is the next rising edge.

Structure
REQ-031 Opcode constants, ALUControl codes and ResultSrc codes in shared package rv32i_pkg.
REQ-032 Register file is one sub-module, regfile; decoder and immediate generator stay inline.

Verification
REQ-033 instrD=0x00500093 (addi x1,x0,5) -> next cycle RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, Rs1E=0, ALUControlE=0000.
REQ-034 RegWriteW=1, RdW=3, ResultW=0xDEADBEEF with instrD=0x00318233 same cycle -> next cycle RD1E=RD2E=0xDEADBEEF, RdE=4.
REQ-035 instrD=0xFE000EE3 (beq x0,x0,-4) -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=0001, RegWriteE=0; instrD=0x0020A423 (sw x2,8(x1)) -> ImmExtE=8, MemWriteE=1, RegWriteE=0.
REQ-036 Write x0 with 0x1234, then instrD=0x00000033 -> RD1E=RD2E=0.
REQ-037 Valid addi with flushE=1 -> all controls 0; stallD=1 for 3 cycles -> E outputs unchanged; both asserted -> bubble.
REQ-038 rst low mid-stream -> outputs 0 immediately without a clock edge; prior-written registers read back 0.
